// File: rtl/liang_pkg.sv
// Shared pipeline types: register addresses, element type
// and the writeback-to-regfile write request bundle.
package liang_pkg;

   localparam int NREG       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef logic [XLEN-1:0]       ele_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      logic      rd_wen;
      reg_addr_t rd;
      ele_t      rd_wdata;
   } wb_req_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// Pending-write scoreboard: one busy bit per register,
// issue sets, writeback clears, set wins on a collision.
module pipe_scoreboard
   import liang_pkg::*;
#(
   parameter int NREG = liang_pkg::NREG
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      set_en_i,
   input  reg_addr_t set_rd_i,
   input  logic      clr_en_i,
   input  reg_addr_t clr_rd_i,
   input  reg_addr_t rs1_addr_i,
   input  reg_addr_t rs2_addr_i,
   output logic      rs1_busy_o,
   output logic      rs2_busy_o
);

   logic [NREG-1:0] busy;
   logic            set_hit;
   logic            clr_hit;

   assign set_hit = set_en_i && (set_rd_i != '0);
   assign clr_hit = clr_en_i && (clr_rd_i != '0);

   // clear first so a same-register set in this cycle overrides it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy <= '0;
      end else begin
         if (clr_hit) busy[clr_rd_i] <= 1'b0;
         if (set_hit) busy[set_rd_i] <= 1'b1;
      end
   end

   // a value on the write port this cycle is bypassed, so not busy
   always_comb begin
      rs1_busy_o = busy[rs1_addr_i];
      rs2_busy_o = busy[rs2_addr_i];
      if (clr_hit && (clr_rd_i == rs1_addr_i)) rs1_busy_o = 1'b0;
      if (clr_hit && (clr_rd_i == rs2_addr_i)) rs2_busy_o = 1'b0;
      if (rs1_addr_i == '0) rs1_busy_o = 1'b0;
      if (rs2_addr_i == '0) rs2_busy_o = 1'b0;
   end

endmodule

// File: rtl/pipe_regfile.sv
// Architectural integer register file: two bypassed read ports,
// a raw debug read port and a pending-write scoreboard.
module pipe_regfile
   import liang_pkg::*;
#(
   parameter int NREG = liang_pkg::NREG,
   parameter int XLEN = liang_pkg::XLEN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  wb_req_t         wb_req_i,
   input  reg_addr_t       rs1_addr_i,
   output logic [XLEN-1:0] rs1_data_o,
   input  reg_addr_t       rs2_addr_i,
   output logic [XLEN-1:0] rs2_data_o,
   input  logic            iss_valid_i,
   input  reg_addr_t       iss_rd_i,
   output logic            rs1_busy_o,
   output logic            rs2_busy_o,
   input  reg_addr_t       dbg_addr_i,
   output logic [XLEN-1:0] dbg_data_o
);

   ele_t regs [NREG];
   logic wr_hit;

   assign wr_hit = wb_req_i.rd_wen && (wb_req_i.rd != '0);

   // single write port; x0 is never written and stays zero
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_hit) begin
         regs[wb_req_i.rd] <= wb_req_i.rd_wdata;
      end
   end

   // read muxes: zero in reset or for x0, else bypass, else array
   always_comb begin
      rs1_data_o = regs[rs1_addr_i];
      rs2_data_o = regs[rs2_addr_i];
      dbg_data_o = regs[dbg_addr_i];
      if (wr_hit && (wb_req_i.rd == rs1_addr_i)) rs1_data_o = wb_req_i.rd_wdata;
      if (wr_hit && (wb_req_i.rd == rs2_addr_i)) rs2_data_o = wb_req_i.rd_wdata;
      if (rst_i || (rs1_addr_i == '0)) rs1_data_o = '0;
      if (rst_i || (rs2_addr_i == '0)) rs2_data_o = '0;
      if (rst_i || (dbg_addr_i == '0)) dbg_data_o = '0;
   end

   pipe_scoreboard #(
      .NREG (NREG)
   ) u_sb (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .set_en_i   (iss_valid_i),
      .set_rd_i   (iss_rd_i),
      .clr_en_i   (wb_req_i.rd_wen),
      .clr_rd_i   (wb_req_i.rd),
      .rs1_addr_i (rs1_addr_i),
      .rs2_addr_i (rs2_addr_i),
      .rs1_busy_o (rs1_busy_o),
      .rs2_busy_o (rs2_busy_o)
   );

endmodule

// File: tb/tb_pipe_regfile.sv
// Randomized bench for pipe_regfile against an array-based
// model of architectural state and pending writes.
module tb_pipe_regfile;
   import liang_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   wb_req_t     wb;
   reg_addr_t   a1, a2, ird, dba;
   logic        iss;
   logic [31:0] d1, d2, dd;
   logic        b1, b2;

   int vec  = 0;
   int errs = 0;

   logic [31:0] m_reg  [32];
   logic        m_busy [32];

   always #5 clk = ~clk;

   pipe_regfile dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .wb_req_i    (wb),
      .rs1_addr_i  (a1),
      .rs1_data_o  (d1),
      .rs2_addr_i  (a2),
      .rs2_data_o  (d2),
      .iss_valid_i (iss),
      .iss_rd_i    (ird),
      .rs1_busy_o  (b1),
      .rs2_busy_o  (b2),
      .dbg_addr_i  (dba),
      .dbg_data_o  (dd)
   );

   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(reg_addr_t a);
      if (rst || a == 0) return 0;
      if (wb.rd_wen && wb.rd == a) return wb.rd_wdata;
      return m_reg[a];
   endfunction

   function automatic logic m_bsy(reg_addr_t a);
      if (rst || a == 0) return 0;
      if (wb.rd_wen && wb.rd == a) return 0;
      return m_busy[a];
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = 0;
         m_busy[i] = 0;
      end
   endtask

   task automatic check_all();
      cmp("rs1_data", d1, m_read(a1));
      cmp("rs2_data", d2, m_read(a2));
      cmp("rs1_busy", {31'd0, b1}, {31'd0, m_bsy(a1)});
      cmp("rs2_busy", {31'd0, b2}, {31'd0, m_bsy(a2)});
      cmp("dbg_data", dd, (rst || dba == 0) ? 32'd0 : m_reg[dba]);
   endtask

   task automatic drive(logic w, int rd, logic [31:0] wd, logic i,
                        int ir, int r1, int r2, int db);
      wb.rd_wen   = w;
      wb.rd       = reg_addr_t'(rd);
      wb.rd_wdata = wd;
      iss = i;
      ird = reg_addr_t'(ir);
      a1  = reg_addr_t'(r1);
      a2  = reg_addr_t'(r2);
      dba = reg_addr_t'(db);
   endtask

   // check the settled outputs, take the edge, advance the model
   task automatic cyc();
      #2 check_all();
      @(posedge clk);
      if (!rst) begin
         if (wb.rd_wen && wb.rd != 0) begin
            m_reg[wb.rd]  = wb.rd_wdata;
            m_busy[wb.rd] = 0;
         end
         if (iss && ird != 0) m_busy[ird] = 1;
      end
      @(negedge clk);
   endtask

   function automatic reg_addr_t raddr();
      if ($urandom_range(0, 3) == 0) return reg_addr_t'($urandom_range(0, 31));
      return reg_addr_t'($urandom_range(0, 7));
   endfunction

   initial begin
      m_clear();
      drive(1, 5, 32'hFFFF_FFFF, 1, 6, 5, 6, 5);
      #3 check_all();
      cmp("rst_bypass_blocked", d1, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 1, 1, 1);
      for (int r = 1; r < 32; r++) begin
         a1 = reg_addr_t'(r);
         a2 = reg_addr_t'(32 - r);
         dba = reg_addr_t'(r);
         cyc();
      end

      drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 5);
      #2 cmp("x5_bypass", d1, 32'hDEADBEEF);
      cmp("x5_dbg_before", dd, 32'd0);
      cyc();
      drive(0, 5, 0, 0, 0, 5, 0, 5);
      #2 cmp("x5_held", d1, 32'hDEADBEEF);
      cmp("x5_dbg", dd, 32'hDEADBEEF);
      cyc();

      drive(1, 0, 32'h1234, 0, 0, 0, 0, 0);
      #2 cmp("x0_same", d1, 32'd0);
      cmp("x0_dbg_same", dd, 32'd0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2 cmp("x0_after", d1, 32'd0);
      cyc();

      drive(0, 0, 0, 1, 7, 0, 7, 0);
      #2 cmp("x7_busy_setcyc", {31'd0, b2}, 32'd0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 7, 0);
      #2 cmp("x7_busy", {31'd0, b2}, 32'd1);
      cyc();
      drive(1, 7, 32'h55, 0, 0, 0, 7, 0);
      #2 cmp("x7_clr_busy", {31'd0, b2}, 32'd0);
      cmp("x7_clr_data", d2, 32'h55);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 7, 0);
      #2 cmp("x7_after", {31'd0, b2}, 32'd0);
      cyc();

      drive(0, 0, 0, 1, 9, 9, 0, 9);
      cyc();
      drive(1, 9, 32'h11, 1, 9, 9, 0, 9);
      cyc();
      drive(0, 0, 0, 0, 0, 9, 0, 9);
      #2 cmp("x9_setwins", {31'd0, b1}, 32'd1);
      cmp("x9_data", dd, 32'h11);
      cyc();

      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 1), int'(raddr()), $urandom,
               $urandom_range(0, 1), int'(raddr()),
               int'(raddr()), int'(raddr()), int'(raddr()));
         cyc();
      end

      drive(1, 3, 32'hA, 1, 4, 3, 4, 3);
      cyc();
      drive(0, 0, 0, 0, 0, 3, 4, 3);
      #2 cmp("pre_rst_x3", d1, 32'hA);
      cmp("pre_rst_x4", {31'd0, b2}, 32'd1);
      #1 rst = 1'b1;
      #1 cmp("async_x3", d1, 32'd0);
      cmp("async_x4", {31'd0, b2}, 32'd0);
      cmp("async_dbg", dd, 32'd0);
      m_clear();
      @(negedge clk);
      cyc();
      rst = 1'b0;
      #2 cmp("post_rst_x3", d1, 32'd0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
